// File: rtl/corrode_pkg.sv
// corrode_pkg: shared geometry and FSM encoding for the
// streaming 3x3 erosion stage feeding the display bitmap RAM.
package corrode_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 64;
  localparam int ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    EDGE,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/corrode_line_buf.sv
// corrode_line_buf: DEPTH-deep 1-bit shift buffer; dout is the
// bit pushed DEPTH enables ago, i.e. the same column one row up.
module corrode_line_buf #(
  parameter int DEPTH = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/corrode_wr_ctrl.sv
// corrode_wr_ctrl: streaming 3x3 binary erosion writing one bit
// per pixel, in ascending address order, into the bitmap RAM.
module corrode_wr_ctrl #(
  parameter int IMG_W  = corrode_pkg::IMG_W,
  parameter int IMG_H  = corrode_pkg::IMG_H,
  parameter int ADDR_W = corrode_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_sof,
  input  logic              in_de,
  input  logic              in_bin,
  output logic              in_rdy,
  output logic              wr_ce,
  output logic [ADDR_W-1:0] wr_ad,
  output logic              wr_din,
  output logic              busy,
  output logic              frame_done
);

  import corrode_pkg::*;

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NPIX = IMG_W * IMG_H;

  state_t state, state_nx;

  logic [CW-1:0] col, col_nx, xi;
  logic [RW-1:0] row, row_nx, yi;
  logic last_row, last_nx;
  logic [1:0] w_top, w_mid, w_bot;
  logic lb1_q, lb2_q;
  logic acc, take, col_end, row_end, center;
  logic [ADDR_W-1:0] ya, xa, pix_ad, ad_nx;
  logic ce_nx, din_nx;

  assign acc  = in_de && in_rdy;
  assign take = acc && ((state == RUN) || in_sof);
  assign xi   = in_sof ? '0 : col;
  assign yi   = in_sof ? '0 : row;

  assign col_end = (xi == CW'(IMG_W - 1));
  assign row_end = (yi == RW'(IMG_H - 1));

  // centre of the window is one column left and one row up
  assign ya     = ADDR_W'(yi - RW'(1));
  assign xa     = ADDR_W'(xi - CW'(1));
  assign pix_ad = ya * ADDR_W'(IMG_W) + xa;

  assign center = &{w_top, lb2_q, w_mid, lb1_q, w_bot, in_bin};

  corrode_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (acc),
    .din  (in_bin),
    .dout (lb1_q)
  );

  corrode_line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (acc),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    last_nx  = last_row;
    ce_nx    = 1'b0;
    ad_nx    = wr_ad;
    din_nx   = 1'b0;
    if (take) begin
      state_nx = RUN;
      col_nx   = col_end ? '0 : xi + CW'(1);
      row_nx   = !col_end ? yi : (row_end ? '0 : yi + RW'(1));
      if (xi != '0 && yi != '0) begin
        ce_nx  = 1'b1;
        ad_nx  = pix_ad;
        din_nx = center && (xi != CW'(1)) && (yi != RW'(1));
      end
      if (col_end && yi != '0) begin
        state_nx = EDGE;
        last_nx  = row_end;
      end
    end
    // EDGE and FLUSH write border zeros at the next address
    unique case (state)
      IDLE, RUN: begin
      end
      EDGE: begin
        ce_nx    = 1'b1;
        ad_nx    = wr_ad + ADDR_W'(1);
        state_nx = last_row ? FLUSH : RUN;
      end
      FLUSH: begin
        ce_nx = 1'b1;
        ad_nx = wr_ad + ADDR_W'(1);
        if (ad_nx == ADDR_W'(NPIX - 1)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      last_row   <= 1'b0;
      w_top      <= '0;
      w_mid      <= '0;
      w_bot      <= '0;
      in_rdy     <= 1'b0;
      wr_ce      <= 1'b0;
      wr_ad      <= '0;
      wr_din     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      last_row   <= last_nx;
      in_rdy     <= (state_nx == IDLE) || (state_nx == RUN);
      wr_ce      <= ce_nx;
      wr_ad      <= ad_nx;
      wr_din     <= din_nx;
      busy       <= (state_nx != IDLE);
      frame_done <= (state == DONE);
      if (acc) begin
        if (in_sof) begin
          w_top <= '0;
          w_mid <= '0;
          w_bot <= '0;
        end else begin
          w_top <= {w_top[0], lb2_q};
          w_mid <= {w_mid[0], lb1_q};
          w_bot <= {w_bot[0], in_bin};
        end
      end
    end
  end

endmodule

// File: tb/tb_corrode_wr_ctrl.sv
// tb_corrode_wr_ctrl: random-stimulus bench with a frame-level
// erosion model checked against the RAM write stream every cycle.
module tb_corrode_wr_ctrl;

  localparam int W  = 128;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_sof = 1'b0, in_de = 1'b0, in_bin = 1'b0;
  logic in_rdy, wr_ce, wr_din, busy, frame_done;
  logic [AW-1:0] wr_ad;

  always #5 clk = ~clk;

  corrode_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_sof(in_sof), .in_de(in_de),
    .in_bin(in_bin), .in_rdy(in_rdy), .wr_ce(wr_ce), .wr_ad(wr_ad),
    .wr_din(wr_din), .busy(busy), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_err = 0;

  bit img[N];
  int mx, my, stall, pend_addr, nexp;
  bit active, infr, endf, pend, done_exp;
  int wr_cnt, ones_cnt, done_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit border(input int a);
    int x, y;
    x = a % W;
    y = a / W;
    return x == 0 || y == 0 || x == W - 1 || y == H - 1;
  endfunction

  function automatic bit erode(input int a);
    int x, y;
    bit r;
    if (border(a)) return 1'b0;
    x = a % W;
    y = a / W;
    r = 1'b1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        r &= img[(y + dy) * W + x + dx];
    return r;
  endfunction

  function automatic bit pix(input int kind, input int x, input int y);
    case (kind)
      0: return 1'b1;
      1: return !(x == 10 && y == 10);
      2: return ((x + y) % 2) == 1;
      default: return $urandom_range(0, 15) != 0;
    endcase
  endfunction

  // model: expected writes, stalls, busy and done from the frame rules
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; infr = 0; endf = 0; pend = 0; done_exp = 0;
      stall = 0; nexp = 0; mx = 0; my = 0;
    end else begin
      chk("in_rdy", int'(in_rdy), int'(stall == 0));
      chk("busy", int'(busy), int'(infr));
      chk("frame_done", int'(frame_done), int'(done_exp));
      if (frame_done) done_cnt++;
      done_exp = 0;
      if (pend) begin
        chk("pix_wr_ce", int'(wr_ce), 1);
        chk("pix_wr_ad", int'(wr_ad), pend_addr);
        chk("pix_wr_din", int'(wr_din), int'(erode(pend_addr)));
      end else if (wr_ce) begin
        chk("bdr_open", int'(infr && nexp < N), 1);
        chk("bdr_wr_ad", int'(wr_ad), nexp);
        chk("bdr_pos", int'(border(int'(wr_ad))), 1);
        chk("bdr_wr_din", int'(wr_din), 0);
      end
      if (wr_ce) begin
        if (pend) chk("wr_order", int'(wr_ad), nexp);
        wr_cnt++;
        if (wr_din) ones_cnt++;
        done_exp = (int'(wr_ad) == N - 1);
        nexp++;
      end
      pend = 0;
      if (stall > 0) begin
        stall--;
        if (stall == 0 && endf) begin
          infr = 0;
          endf = 0;
        end
      end
      if (in_de && in_rdy) begin
        if (in_sof) begin
          mx = 0; my = 0; active = 1; infr = 1;
          nexp = 0; wr_cnt = 0; ones_cnt = 0;
        end
        if (active) begin
          img[my * W + mx] = in_bin;
          if (mx >= 1 && my >= 1) begin
            pend = 1;
            pend_addr = (my - 1) * W + mx - 1;
          end
          if (mx == W - 1 && my >= 1) begin
            stall = (my == H - 1) ? W + 2 : 1;
            endf = (my == H - 1);
          end
          if (mx == W - 1) begin
            mx = 0;
            my++;
            if (my == H) begin
              my = 0;
              active = 0;
            end
          end else begin
            mx++;
          end
        end
      end
    end
  end

  task automatic drive(input int kind, input bit cont, input int abort_row,
                       input int stop_n, output int lows, output int accs);
    int n, x, y, guard;
    bit s, aborted, r;
    n = 0; aborted = 0; lows = 0; accs = 0; guard = 0;
    while (n < N && !(stop_n > 0 && accs >= stop_n) && guard < 40000) begin
      x = n % W;
      y = n / W;
      s = (n == 0) || (!aborted && abort_row >= 0 && y == abort_row && x == 5);
      if (s) begin
        x = 0;
        y = 0;
      end
      in_sof = s;
      in_bin = pix(kind, x, y);
      in_de  = cont || ($urandom_range(0, 7) != 0);
      r = in_rdy;
      if (!r) lows++;
      @(posedge clk);
      #1;
      guard++;
      if (in_de && r) begin
        accs++;
        if (s && n != 0) aborted = 1;
        n = s ? 1 : n + 1;
      end
    end
    in_de = 0;
    in_sof = 0;
    if (guard >= 40000) chk("drive_timeout", guard, 0);
  endtask

  task automatic frame(input int kind, input bit cont, input int abort_row,
                       input int exp_ones, input int exp_lows);
    int lows, accs, k, d0;
    d0 = done_cnt;
    drive(kind, cont, abort_row, 0, lows, accs);
    k = 0;
    while (!in_rdy && k < 400) begin
      lows++;
      @(posedge clk);
      #1;
      k++;
    end
    chk("end_stall_bound", int'(k < 400), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_writes", wr_cnt, N);
    chk("frame_done_cnt", done_cnt - d0, 1);
    if (exp_ones >= 0) chk("frame_ones", ones_cnt, exp_ones);
    if (exp_lows >= 0) begin
      chk("rdy_low_cycles", lows, exp_lows);
      chk("accepted", accs, N);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, accs;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", int'(in_rdy), 0);
    chk("rst_wr_ce", int'(wr_ce), 0);
    chk("rst_wr_ad", int'(wr_ad), 0);
    chk("rst_wr_din", int'(wr_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", int'(in_rdy), 1);

    in_de = 1; in_bin = 1;
    repeat (5) @(posedge clk);
    #1;
    in_de = 0;
    chk("idle_discard_busy", int'(busy), 0);

    frame(0, 1'b1, -1, 7812, 192);
    frame(1, 1'b0, -1, 7803, -1);
    frame(2, 1'b0, -1, 0, -1);
    frame(3, 1'b0, -1, -1, -1);
    frame(0, 1'b0, 20, 7812, -1);

    drive(0, 1'b0, -1, 3000, lows, accs);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rdy", int'(in_rdy), 0);
    chk("async_wr_ce", int'(wr_ce), 0);
    chk("async_wr_ad", int'(wr_ad), 0);
    chk("async_wr_din", int'(wr_din), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(1, 1'b0, -1, 7803, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
